// File: rtl/axis_position_ctrl.sv
// axis_position_ctrl
//   Single-axis position counter for the cube's X/Y movement. Moves between
//   programmable bounds on game-rate ticks, saturating or wrapping at the
//   ends, and switches from slow to fast stepping after HOLD_TICKS
//   consecutive slow moves in the same direction.
// Ports:
//   clk      system clock, all state changes on its rising edge
//   reset    asynchronous active-high reset
//   tick_en  move qualifier; moves only on cycles with tick_en=1
//   UP, DW   move request toward MAX_POS / MIN_POS (levels)
//   LD, D    synchronous load of clamp(D), independent of tick_en
//   pos      current position register
//   at_max   pos == MAX_POS
//   at_min   pos == MIN_POS
//   hit_max  registered pulse: an up move reached or crossed MAX_POS
//   hit_min  registered pulse: a down move reached or crossed MIN_POS
//   fast     FSM is in the FAST state
module axis_position_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MIN_POS    = 0,
  parameter int unsigned MAX_POS    = 605,
  parameter int unsigned RESET_POS  = 0,
  parameter int unsigned STEP_SLOW  = 1,
  parameter int unsigned STEP_FAST  = 4,
  parameter int unsigned HOLD_TICKS = 8,
  parameter bit          WRAP       = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             UP,
  input  logic             DW,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] pos,
  output logic             at_max,
  output logic             at_min,
  output logic             hit_max,
  output logic             hit_min,
  output logic             fast
);

  localparam int unsigned      HW      = $clog2(HOLD_TICKS + 1);
  localparam logic [WIDTH:0]   MIN_W   = (WIDTH+1)'(MIN_POS);
  localparam logic [WIDTH:0]   MAX_W   = (WIDTH+1)'(MAX_POS);
  localparam logic [WIDTH:0]   RANGE_W = (WIDTH+1)'(MAX_POS - MIN_POS + 1);
  localparam logic [WIDTH:0]   SLOW_W  = (WIDTH+1)'(STEP_SLOW);
  localparam logic [WIDTH:0]   FAST_W  = (WIDTH+1)'(STEP_FAST);
  localparam logic [HW-1:0]    HOLD_W  = HW'(HOLD_TICKS);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_POS);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

  state_t           state, state_nx;
  logic             dir, dir_nx;          // 1 = toward MAX_POS
  logic [HW-1:0]    hold_cnt, hold_nx;
  logic [WIDTH-1:0] pos_nx;
  logic             hit_max_nx, hit_min_nx;
  logic             use_fast;
  logic [WIDTH:0]   step, up_sum, dn_off, d_ext, d_rel;

  always_comb begin
    state_nx   = state;
    dir_nx     = dir;
    hold_nx    = hold_cnt;
    pos_nx     = pos;
    hit_max_nx = 1'b0;
    hit_min_nx = 1'b0;
    use_fast   = 1'b0;
    step       = SLOW_W;
    up_sum     = '0;
    dn_off     = '0;
    d_ext      = {1'b0, D};
    // borrow out of D-MIN_POS flags D below the lower bound
    d_rel      = d_ext - MIN_W;

    if (LD) begin
      state_nx = IDLE;
      hold_nx  = '0;
      if (d_rel[WIDTH])
        pos_nx = MIN_W[WIDTH-1:0];
      else if (d_ext > MAX_W)
        pos_nx = MAX_W[WIDTH-1:0];
      else
        pos_nx = D;
    end else if (tick_en) begin
      if (UP ^ DW) begin
        if (state == IDLE || dir != UP) begin
          state_nx = SLOW;
          dir_nx   = UP;
          hold_nx  = HW'(1);
        end else if (state == SLOW) begin
          if (hold_cnt == HOLD_W) begin
            state_nx = FAST;
            use_fast = 1'b1;
          end else begin
            hold_nx = hold_cnt + 1'b1;
          end
        end else begin
          use_fast = 1'b1;
        end

        step   = use_fast ? FAST_W : SLOW_W;
        up_sum = {1'b0, pos} + step;
        // distance above the lower bound; comparing it with step avoids a
        // signed difference when pos-step would drop below MIN_POS
        dn_off = {1'b0, pos} - MIN_W;

        if (UP) begin
          hit_max_nx = (up_sum >= MAX_W);
          if (up_sum <= MAX_W)
            pos_nx = up_sum[WIDTH-1:0];
          else if (WRAP)
            pos_nx = WIDTH'(up_sum - RANGE_W);
          else
            pos_nx = MAX_W[WIDTH-1:0];
        end else begin
          hit_min_nx = (dn_off <= step);
          if (dn_off >= step)
            pos_nx = WIDTH'({1'b0, pos} - step);
          else if (WRAP)
            pos_nx = WIDTH'({1'b0, pos} + RANGE_W - step);
          else
            pos_nx = MIN_W[WIDTH-1:0];
        end
      end else begin
        state_nx = IDLE;
        hold_nx  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dir      <= 1'b0;
      hold_cnt <= '0;
      pos      <= RESET_W;
      hit_max  <= 1'b0;
      hit_min  <= 1'b0;
    end else begin
      state    <= state_nx;
      dir      <= dir_nx;
      hold_cnt <= hold_nx;
      pos      <= pos_nx;
      hit_max  <= hit_max_nx;
      hit_min  <= hit_min_nx;
    end
  end

  assign at_max = (pos == MAX_W[WIDTH-1:0]);
  assign at_min = (pos == MIN_W[WIDTH-1:0]);
  assign fast   = (state == FAST);

endmodule

// File: tb/tb_axis_position_ctrl.sv
// Testbench for axis_position_ctrl. Two instances share one stimulus stream:
// index 0 saturates at the bounds, index 1 wraps.
module tb_axis_position_ctrl;

  localparam int MINP  = 0;
  localparam int MAXP  = 605;
  localparam int RANGE = MAXP - MINP + 1;
  localparam int SLOWS = 1;
  localparam int FASTS = 4;
  localparam int HOLD  = 8;

  logic        clk = 1'b0;
  logic        reset, tick_en, UP, DW, LD;
  logic [15:0] D;
  logic [15:0] pos0, pos1;
  logic        amax0, amin0, hmax0, hmin0, fast0;
  logic        amax1, amin1, hmax1, hmin1, fast1;

  always #5 clk = ~clk;

  axis_position_ctrl #(
    .WIDTH(16), .MIN_POS(0), .MAX_POS(605), .RESET_POS(0),
    .STEP_SLOW(1), .STEP_FAST(4), .HOLD_TICKS(8), .WRAP(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .UP(UP), .DW(DW), .LD(LD), .D(D),
    .pos(pos0), .at_max(amax0), .at_min(amin0), .hit_max(hmax0), .hit_min(hmin0),
    .fast(fast0)
  );

  axis_position_ctrl #(
    .WIDTH(16), .MIN_POS(0), .MAX_POS(605), .RESET_POS(0),
    .STEP_SLOW(1), .STEP_FAST(4), .HOLD_TICKS(8), .WRAP(1'b1)
  ) dut_w (
    .clk(clk), .reset(reset), .tick_en(tick_en), .UP(UP), .DW(DW), .LD(LD), .D(D),
    .pos(pos1), .at_max(amax1), .at_min(amin1), .hit_max(hmax1), .hit_min(hmin1),
    .fast(fast1)
  );

  typedef struct {
    int pos;
    bit hmax;
    bit hmin;
    bit fast;
    bit amax;
    bit amin;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: mode 0 = idle, 1 = slow, 2 = fast
  int mpos[2];
  int mmode[2];
  int mhold[2];
  bit mdir[2];
  bit mhmax[2];
  bit mhmin[2];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mpos[k]  = 0;
      mmode[k] = 0;
      mhold[k] = 0;
      mdir[k]  = 1'b0;
      mhmax[k] = 1'b0;
      mhmin[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input bit wrap, input bit ld, input int d,
                            input bit te, input bit up, input bit dw);
    int step;
    int s;
    mhmax[k] = 1'b0;
    mhmin[k] = 1'b0;
    if (ld) begin
      mpos[k]  = (d < MINP) ? MINP : ((d > MAXP) ? MAXP : d);
      mmode[k] = 0;
      mhold[k] = 0;
    end else if (te) begin
      if (up != dw) begin
        if (mmode[k] == 0 || mdir[k] != up) begin
          mmode[k] = 1;
          mdir[k]  = up;
          mhold[k] = 1;
          step     = SLOWS;
        end else if (mmode[k] == 1) begin
          if (mhold[k] == HOLD) begin
            mmode[k] = 2;
            step     = FASTS;
          end else begin
            mhold[k] = mhold[k] + 1;
            step     = SLOWS;
          end
        end else begin
          step = FASTS;
        end
        if (up) begin
          s = mpos[k] + step;
          mhmax[k] = (s >= MAXP);
          if (s > MAXP) s = wrap ? s - RANGE : MAXP;
        end else begin
          s = mpos[k] - step;
          mhmin[k] = (s <= MINP);
          if (s < MINP) s = wrap ? s + RANGE : MINP;
        end
        mpos[k] = s;
      end else begin
        mmode[k] = 0;
        mhold[k] = 0;
      end
    end
  endtask

  function automatic exp_t expect_of(input int k);
    exp_t e;
    e.pos  = mpos[k];
    e.hmax = mhmax[k];
    e.hmin = mhmin[k];
    e.fast = (mmode[k] == 2);
    e.amax = (mpos[k] == MAXP);
    e.amin = (mpos[k] == MINP);
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input int p, input bit amx,
                     input bit amn, input bit hmx, input bit hmn, input bit fst);
    chk({tag, "_pos"},     p,   e.pos);
    chk({tag, "_at_max"},  amx, e.amax);
    chk({tag, "_at_min"},  amn, e.amin);
    chk({tag, "_hit_max"}, hmx, e.hmax);
    chk({tag, "_hit_min"}, hmn, e.hmin);
    chk({tag, "_fast"},    fst, e.fast);
  endtask

  // scoreboard monitor: one expected entry per instance per clock edge
  always @(posedge clk) begin : monitor
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      cmp("sat", e, pos0, amax0, amin0, hmax0, hmin0, fast0);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      cmp("wrap", e, pos1, amax1, amin1, hmax1, hmin1, fast1);
    end
  end

  task automatic cycle(input bit ld, input int d, input bit te, input bit up, input bit dw);
    @(negedge clk);
    reset   = 1'b0;
    LD      = ld;
    D       = 16'(d);
    tick_en = te;
    UP      = up;
    DW      = dw;
    model_step(0, 1'b0, ld, d, te, up, dw);
    model_step(1, 1'b1, ld, d, te, up, dw);
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // reset asserted between edges; outputs must clear before any clock edge
  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_sat_pos",   pos0,  0);
    chk("async_sat_fast",  fast0, 0);
    chk("async_wrap_pos",  pos1,  0);
    chk("async_wrap_fast", fast1, 0);
    model_reset();
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
  endtask

  int t2[11];
  int t3[7];

  initial begin
    bit cur_up;
    int r;
    bit ld, te, up, dw;
    t2 = '{1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20};
    t3 = '{601, 602, 603, 604, 605, 605, 605};

    reset = 1'b1; LD = 1'b0; D = '0; tick_en = 1'b0; UP = 1'b0; DW = 1'b0;
    model_reset();
    #1;
    chk("rst_pos",     pos0,  0);
    chk("rst_at_min",  amin0, 1);
    chk("rst_at_max",  amax0, 0);
    chk("rst_fast",    fast0, 0);
    chk("rst_hit_max", hmax0, 0);
    chk("rst_hit_min", hmin0, 0);

    // slow then fast stepping from 0
    for (int i = 0; i < 11; i++) begin
      cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
      settle();
      chk("accel_pos",  pos0,  t2[i]);
      chk("accel_fast", fast0, (i >= 8) ? 1 : 0);
    end

    // saturation at MAX_POS
    cycle(1'b1, 600, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
      settle();
      chk("sat_pos",     pos0,  t3[i]);
      chk("sat_hit_max", hmax0, (i >= 4) ? 1 : 0);
    end

    // wrap across both bounds
    cycle(1'b1, 604, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("wrap1_pos", pos1, 605);
    chk("wrap1_hit_max", hmax1, 1);
    cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("wrap2_pos", pos1, 0);
    chk("wrap2_hit_max", hmax1, 1);
    cycle(1'b0, 0, 1'b1, 1'b0, 1'b1);
    settle();
    chk("wrap3_pos", pos1, 605);
    chk("wrap3_hit_min", hmin1, 1);
    chk("wrap3_fast", fast1, 0);

    // conflicting request drops out of FAST; load clamps and wins over move
    cycle(1'b1, 0, 1'b0, 1'b0, 1'b0);
    repeat (9) cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("both_pre_fast", fast0, 1);
    chk("both_pre_pos",  pos0,  12);
    cycle(1'b0, 0, 1'b1, 1'b1, 1'b1);
    settle();
    chk("both_pos",  pos0,  12);
    chk("both_fast", fast0, 0);
    cycle(1'b1, 700, 1'b1, 1'b1, 1'b0);
    settle();
    chk("ldclamp_pos",  pos0,  605);
    chk("ldclamp_fast", fast0, 0);

    // asynchronous reset while in FAST at 300
    cycle(1'b1, 264, 1'b0, 1'b0, 1'b0);
    repeat (15) cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("pre_rst_pos",  pos0,  300);
    chk("pre_rst_fast", fast0, 1);
    async_reset();
    cycle(1'b0, 0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("post_rst_pos", pos0, 1);

    // randomized traffic with persistent direction to reach FAST often
    cur_up = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 19) == 0) cur_up = ~cur_up;
        ld = ($urandom_range(0, 31) == 0);
        te = ($urandom_range(0, 3) != 0);
        r  = $urandom_range(0, 15);
        if (r == 0) begin
          up = 1'b1; dw = 1'b1;
        end else if (r == 1) begin
          up = 1'b0; dw = 1'b0;
        end else begin
          up = cur_up; dw = ~cur_up;
        end
        cycle(ld, $urandom_range(0, 700), te, up, dw);
      end
    end

    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("queue_drain", q0.size() + q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
